gpr_access_ctrl: RTL and testbench

- Initiator side of the single-port `gpr` register file. It owns the GPR `address`, `d` and `wren` inputs and samples the GPR `q` output.
- It serialises pipeline traffic onto that one port: a register-read request (rs, rt) and write-back requests (rd, data).
- It enforces MIPS register-0 semantics and orders write-back before a read accepted in the same cycle.
- It sits between the decode/writeback stages and `gpr`.

---
 rtl/gpr_access_ctrl_if.sv | 41 ++++
 rtl/gpr_access_ctrl.sv | 98 +++++++++
 tb/tb_gpr_access_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_access_ctrl_if.sv
// gpr_access_ctrl_if: bundles the pipeline read/write-back handshakes and the gpr port.
// Ports (slave = controller side):
//   rd_req_valid/rd_req_ready, rs_addr, rt_addr     register-read request
//   rd_resp_valid/rd_resp_ready, rs_data, rt_data   register-read response
//   wb_valid/wb_ready, wb_addr, wb_data             write-back request
//   gpr_address, gpr_d, gpr_wren, gpr_q             single gpr port
interface gpr_access_ctrl_if #(
    parameter int N = 32,
    parameter int K = 5
);
    logic         rd_req_valid;
    logic         rd_req_ready;
    logic [K-1:0] rs_addr;
    logic [K-1:0] rt_addr;
    logic         rd_resp_valid;
    logic         rd_resp_ready;
    logic [N-1:0] rs_data;
    logic [N-1:0] rt_data;
    logic         wb_valid;
    logic         wb_ready;
    logic [K-1:0] wb_addr;
    logic [N-1:0] wb_data;
    logic [K-1:0] gpr_address;
    logic [N-1:0] gpr_d;
    logic         gpr_wren;
    logic [N-1:0] gpr_q;

    modport master (
        output rd_req_valid, rs_addr, rt_addr, rd_resp_ready,
        output wb_valid, wb_addr, wb_data, gpr_q,
        input  rd_req_ready, rd_resp_valid, rs_data, rt_data,
        input  wb_ready, gpr_address, gpr_d, gpr_wren
    );

    modport slave (
        input  rd_req_valid, rs_addr, rt_addr, rd_resp_ready,
        input  wb_valid, wb_addr, wb_data, gpr_q,
        output rd_req_ready, rd_resp_valid, rs_data, rt_data,
        output wb_ready, gpr_address, gpr_d, gpr_wren
    );
endinterface

// File: rtl/gpr_access_ctrl.sv
// gpr_access_ctrl: serialises register reads and write-backs onto the single gpr port.
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  gpr_access_ctrl_if.slave: read request/response, write-back, gpr port
module gpr_access_ctrl #(
    parameter int N    = 32,
    parameter int Nreg = 32,
    parameter int K    = $clog2(Nreg)
) (
    input logic clk,
    input logic rst,
    gpr_access_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WRITE, READ_RS, READ_RT, RESP} state_t;

    state_t       state, state_nx;
    logic         rd_pend, rd_pend_nx;
    logic         wb_full;
    logic [K-1:0] wb_addr_q, rs_q, rt_q;
    logic [N-1:0] wb_data_q, rs_data_q, rt_data_q;
    logic         wb_acc, rd_acc;

    assign wb_acc            = bus.wb_valid && !wb_full;
    assign rd_acc            = bus.rd_req_valid && state == IDLE;
    assign bus.wb_ready      = !wb_full;
    assign bus.rd_req_ready  = state == IDLE;
    assign bus.rd_resp_valid = state == RESP;
    assign bus.rs_data       = rs_data_q;
    assign bus.rt_data       = rt_data_q;

    // All gpr port outputs decode from state only, so reset drops gpr_wren without waiting for a clock.
    always_comb begin
        state_nx        = state;
        rd_pend_nx      = rd_pend;
        bus.gpr_address = '0;
        bus.gpr_d       = wb_data_q;
        bus.gpr_wren    = 1'b0;
        case (state)
            IDLE: begin
                // A buffered or just-arriving write always goes first so the read sees it.
                if (wb_full || wb_acc) begin
                    state_nx   = WRITE;
                    rd_pend_nx = rd_acc;
                end else if (rd_acc) begin
                    state_nx = READ_RS;
                end
            end
            WRITE: begin
                bus.gpr_address = wb_addr_q;
                bus.gpr_wren    = wb_addr_q != '0;
                state_nx        = rd_pend ? READ_RS : IDLE;
                rd_pend_nx      = 1'b0;
            end
            READ_RS: begin
                bus.gpr_address = rs_q;
                state_nx        = READ_RT;
            end
            READ_RT: begin
                bus.gpr_address = rt_q;
                state_nx        = RESP;
            end
            RESP: state_nx = bus.rd_resp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rd_pend   <= 1'b0;
            wb_full   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
        end else begin
            state   <= state_nx;
            rd_pend <= rd_pend_nx;
            // The buffer is always full in WRITE, so drain and load never collide.
            if (state == WRITE) begin
                wb_full <= 1'b0;
            end else if (wb_acc) begin
                wb_full   <= 1'b1;
                wb_addr_q <= bus.wb_addr;
                wb_data_q <= bus.wb_data;
            end
            if (rd_acc) begin
                rs_q <= bus.rs_addr;
                rt_q <= bus.rt_addr;
            end
            if (state == READ_RS) rs_data_q <= rs_q == '0 ? '0 : bus.gpr_q;
            if (state == READ_RT) rt_data_q <= rt_q == '0 ? '0 : bus.gpr_q;
        end
    end
endmodule

// File: tb/tb_gpr_access_ctrl.sv
// tb_gpr_access_ctrl: directed bench for gpr_access_ctrl with a transaction-level reference model.
module tb_gpr_access_ctrl;
    localparam int N    = 32;
    localparam int NREG = 32;
    localparam int K    = 5;

    logic clk = 1'b0;
    logic rst;
    logic gpr_rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    gpr_access_ctrl_if #(.N(N), .K(K)) bus ();

    gpr_access_ctrl #(.N(N), .Nreg(NREG)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // gpr stand-in: combinational read, synchronous write, reset from ~rst.
    // Register 0 holds junk so the controller's own zeroing of r0 reads is exercised.
    logic [N-1:0] regs [NREG];
    assign gpr_rst   = ~rst;
    assign bus.gpr_q = regs[bus.gpr_address];
    always @(posedge clk or posedge gpr_rst) begin
        if (gpr_rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= (i == 0) ? 32'h0BAD0BAD : '0;
        end else if (bus.gpr_wren) begin
            regs[bus.gpr_address] <= bus.gpr_d;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: register contents change when a write is accepted; a read
    // snapshots them at acceptance (after a same-cycle write) and must answer
    // 3 cycles later, or 4 when a write is buffered or arrives with it.
    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [NREG];
    bit          started = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            exp_q.delete();
            started = 0;
            foreach (ref_mem[i]) ref_mem[i] = '0;
        end else begin
            chk("no_r0_write", 32'(bus.gpr_wren && bus.gpr_address == '0), 0);
            if (exp_q.size() == 0) begin
                chk("resp_valid_idle", 32'(bus.rd_resp_valid), 0);
            end else begin
                chk("resp_valid", 32'(bus.rd_resp_valid),
                    32'(started || (cyc - exp_q[0].acc == exp_q[0].lat)));
                if (bus.rd_resp_valid) begin
                    started = 1;
                    chk("rs_data", bus.rs_data, exp_q[0].rs);
                    chk("rt_data", bus.rt_data, exp_q[0].rt);
                    if (bus.rd_resp_ready) begin
                        void'(exp_q.pop_front());
                        started = 0;
                    end
                end
            end
            if (bus.wb_valid && bus.wb_ready && bus.wb_addr != '0) ref_mem[bus.wb_addr] = bus.wb_data;
            if (bus.rd_req_valid && bus.rd_req_ready)
                exp_q.push_back('{rs: ref_mem[bus.rs_addr], rt: ref_mem[bus.rt_addr], acc: cyc,
                                  lat: (bus.wb_valid || !bus.wb_ready) ? 4 : 3});
        end
    end

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        bit ok = 0;
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
        bus.wb_data  = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.wb_ready;
        end
        chk("wb_accept_timeout", 32'(ok), 1);
        @(posedge clk);
        #1 bus.wb_valid = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] rs, input logic [4:0] rt);
        bit ok = 0;
        bus.rd_req_valid = 1'b1;
        bus.rs_addr      = rs;
        bus.rt_addr      = rt;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.rd_req_ready;
        end
        chk("rd_accept_timeout", 32'(ok), 1);
        @(posedge clk);
        #1 bus.rd_req_valid = 1'b0;
    endtask

    task automatic do_both(input logic [4:0] a, input logic [31:0] d,
                           input logic [4:0] rs, input logic [4:0] rt);
        bit ok = 0;
        bus.wb_valid     = 1'b1;
        bus.wb_addr      = a;
        bus.wb_data      = d;
        bus.rd_req_valid = 1'b1;
        bus.rs_addr      = rs;
        bus.rt_addr      = rt;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.rd_req_ready && bus.wb_ready;
        end
        chk("both_accept_timeout", 32'(ok), 1);
        @(posedge clk);
        #1;
        bus.wb_valid     = 1'b0;
        bus.rd_req_valid = 1'b0;
    endtask

    // Counts cycles from just after acceptance until rd_resp_valid; returns at that negedge.
    task automatic wait_resp(output int n);
        bit ok = 0;
        n = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            n++;
            ok = bus.rd_resp_valid;
        end
        chk("resp_timeout", 32'(ok), 1);
    endtask

    initial begin
        int n;
        bus.rd_req_valid  = 1'b0;
        bus.rs_addr       = '0;
        bus.rt_addr       = '0;
        bus.rd_resp_ready = 1'b1;
        bus.wb_valid      = 1'b0;
        bus.wb_addr       = '0;
        bus.wb_data       = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", 32'(bus.rd_resp_valid), 0);
        chk("rst_rs_data", bus.rs_data, 0);
        chk("rst_rt_data", bus.rt_data, 0);
        chk("rst_gpr_wren", 32'(bus.gpr_wren), 0);
        chk("rst_gpr_address", 32'(bus.gpr_address), 0);
        chk("rst_gpr_d", bus.gpr_d, 0);
        chk("rst_wb_ready", 32'(bus.wb_ready), 1);
        chk("rst_rd_req_ready", 32'(bus.rd_req_ready), 1);
        @(posedge clk);
        #1 rst = 1'b1;

        do_write(5, 32'hDEADBEEF);
        do_write(10, 32'hCAFEBABE);
        do_read(5, 10);
        wait_resp(n);
        chk("wr_rd_latency", 32'(n), 3);
        chk("wr_rd_rs", bus.rs_data, 32'hDEADBEEF);
        chk("wr_rd_rt", bus.rt_data, 32'hCAFEBABE);
        @(posedge clk);
        #1;

        do_both(31, 32'h12345678, 31, 0);
        wait_resp(n);
        chk("simul_latency", 32'(n), 4);
        chk("simul_rs", bus.rs_data, 32'h12345678);
        chk("simul_rt", bus.rt_data, 0);
        @(posedge clk);
        #1;

        do_write(0, 32'hFFFFFFFF);
        chk("r0_write_wren", 32'(bus.gpr_wren), 0);
        do_read(0, 31);
        wait_resp(n);
        chk("r0_latency", 32'(n), 3);
        chk("r0_rs", bus.rs_data, 0);
        chk("r0_rt", bus.rt_data, 32'h12345678);
        @(posedge clk);
        #1;

        bus.rd_resp_ready = 1'b0;
        do_read(5, 10);
        @(posedge clk);
        #1;
        do_write(5, 32'hAAAAAAAA);
        wait_resp(n);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(bus.rd_resp_valid), 1);
            chk("bp_hold_rs", bus.rs_data, 32'hDEADBEEF);
        end
        @(posedge clk);
        #1 bus.rd_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        do_read(5, 10);
        wait_resp(n);
        chk("bp_next_latency", 32'(n), 4);
        chk("bp_next_rs", bus.rs_data, 32'hAAAAAAAA);
        chk("bp_next_rt", bus.rt_data, 32'hCAFEBABE);
        @(posedge clk);
        #1;

        do_write(7, 32'h11111111);
        #2;
        chk("mid_rst_wren_before", 32'(bus.gpr_wren), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_wren", 32'(bus.gpr_wren), 0);
        chk("mid_rst_address", 32'(bus.gpr_address), 0);
        chk("mid_rst_wb_ready", 32'(bus.wb_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        do_read(7, 0);
        wait_resp(n);
        chk("post_rst_latency", 32'(n), 3);
        chk("post_rst_rs", bus.rs_data, 0);
        chk("post_rst_rt", bus.rt_data, 0);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
